// File: rtl/serial_parity_receiver.sv
// rtl/serial_parity_receiver.sv - serial parity link receiver: deserializer, parity check, buffered valid/ready word output
// Optional macro SERIAL_PARITY_RECEIVER_ODD_PARITY_EN selects odd parity (default even parity).
module serial_parity_receiver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_valid,
    input  logic             serial_data,
    output logic             serial_ready,
    output logic             parallel_valid,
    input  logic             parallel_ready,
    output logic [WIDTH-1:0] parallel_data,
    output logic             parity_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_PARITY = CNT_W'(WIDTH);

`ifdef SERIAL_PARITY_RECEIVER_ODD_PARITY_EN
    localparam logic PARITY_SENSE = 1'b1;
`else
    localparam logic PARITY_SENSE = 1'b0;
`endif

    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] data_next;
    logic             valid_next;
    logic             err_next;
    logic             in_parity;
    logic             accept;
    logic             load;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            shift_reg      <= '0;
            parallel_valid <= 1'b0;
            parallel_data  <= '0;
            parity_err     <= 1'b0;
        end else begin
            cnt            <= cnt_next;
            shift_reg      <= shift_next;
            parallel_valid <= valid_next;
            parallel_data  <= data_next;
            parity_err     <= err_next;
        end
    end

    // The parity bit is only taken once the held word is free (or leaving this cycle),
    // so a waiting word can never be overwritten.
    always_comb begin
        in_parity    = (cnt == CNT_PARITY);
        serial_ready = in_parity ? (!parallel_valid || parallel_ready) : 1'b1;
        accept       = serial_valid && serial_ready;
        load         = accept && in_parity;

        cnt_next   = cnt;
        shift_next = shift_reg;
        if (accept) begin
            if (in_parity) begin
                cnt_next = '0;
            end else begin
                cnt_next   = cnt + CNT_W'(1);
                shift_next = {serial_data, shift_reg[WIDTH-1:1]};
            end
        end

        valid_next = parallel_valid;
        data_next  = parallel_data;
        err_next   = parity_err;
        if (load) begin
            valid_next = 1'b1;
            data_next  = shift_reg;
            err_next   = (^shift_reg) ^ serial_data ^ PARITY_SENSE;
        end else if (parallel_valid && parallel_ready) begin
            valid_next = 1'b0;
        end
    end

endmodule
